// File: rtl/sync_barrier_ctrl.sv
// -----------------------------------------------------------------------------
// sync_barrier_ctrl
//
// Hardware barrier between N_CORES processor cores. Each core raises a
// one-cycle arrival strobe with its barrier ID. The first member arrival
// latches the participant mask and the barrier ID. When every participant
// has arrived with the same ID, the block sends one release pulse to all
// participants on sync_enable. Protocol violations set sticky error flags.
// An optional timeout moves an incomplete barrier to ERROR, and the block
// stays there until clear_err.
//
// Ports
//   clk                 rising-edge clock
//   reset               asynchronous, active-high reset
//   sync_barrier        per-core barrier ID, core i at [i*W +: W]
//   sync_barrier_en_in  per-core one-cycle arrival strobe
//   participant_mask    cores taking part, sampled on the first arrival
//   timeout_cycles      collection timeout in cycles, 0 = disabled
//   clear_err           clears the sticky flags and leaves ERROR
//   sync_enable         registered one-cycle release pulse per core
//   busy                high in COLLECT, RELEASE and ERROR
//   active_id           ID of the barrier being collected
//   arrived             cores that arrived at the current barrier
//   err_*               sticky error flags
// -----------------------------------------------------------------------------
module sync_barrier_ctrl #(
    parameter int N_CORES            = 4,
    parameter int SYNC_BARRIER_WIDTH = 8,
    parameter int TIMEOUT_WIDTH      = 16
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [N_CORES*SYNC_BARRIER_WIDTH-1:0] sync_barrier,
    input  logic [N_CORES-1:0]                    sync_barrier_en_in,
    input  logic [N_CORES-1:0]                    participant_mask,
    input  logic [TIMEOUT_WIDTH-1:0]              timeout_cycles,
    input  logic                                  clear_err,
    output logic [N_CORES-1:0]                    sync_enable,
    output logic                                  busy,
    output logic [SYNC_BARRIER_WIDTH-1:0]         active_id,
    output logic [N_CORES-1:0]                    arrived,
    output logic                                  err_mismatch,
    output logic                                  err_nonmember,
    output logic                                  err_dup,
    output logic                                  err_timeout
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;
    localparam logic [1:0] S_ERROR   = 2'd3;

    logic [1:0]                    state_q, state_d;
    logic [N_CORES-1:0]            mask_q, mask_d;
    logic [SYNC_BARRIER_WIDTH-1:0] active_id_q, active_id_d;
    logic [N_CORES-1:0]            arrived_q, arrived_d;
    logic [N_CORES-1:0]            sync_enable_q, sync_enable_d;
    logic                          busy_q, busy_d;
    logic [TIMEOUT_WIDTH-1:0]      tmo_q, tmo_d;
    logic                          err_mismatch_q, err_mismatch_d;
    logic                          err_nonmember_q, err_nonmember_d;
    logic                          err_dup_q, err_dup_d;
    logic                          err_timeout_q, err_timeout_d;

    logic [SYNC_BARRIER_WIDTH-1:0] first_id;
    logic [SYNC_BARRIER_WIDTH-1:0] ref_id;
    logic [N_CORES-1:0]            id_match;
    logic [N_CORES-1:0]            member;
    logic [N_CORES-1:0]            fresh;
    logic                          set_mis, set_non, set_dup, set_tmo;

    // Scan from the highest index downwards so that the lowest-index strobing
    // member writes last. That core's ID becomes the barrier ID.
    always_comb begin
        first_id = '0;
        for (int i = N_CORES - 1; i >= 0; i--) begin
            if (sync_barrier_en_in[i] && participant_mask[i]) begin
                first_id = sync_barrier[i*SYNC_BARRIER_WIDTH +: SYNC_BARRIER_WIDTH];
            end
        end
    end

    // In IDLE, IDs are compared against the ID that is about to be latched.
    // In all other states they are compared against the latched ID.
    assign ref_id = (state_q == S_IDLE) ? first_id : active_id_q;

    always_comb begin
        id_match = '0;
        for (int i = 0; i < N_CORES; i++) begin
            id_match[i] = (sync_barrier[i*SYNC_BARRIER_WIDTH +: SYNC_BARRIER_WIDTH] == ref_id);
        end
    end

    // NOTE: every signal assigned below gets a default first, so no path
    // through the case statement leaves one unassigned and infers a latch.
    always_comb begin
        state_d       = state_q;
        mask_d        = mask_q;
        active_id_d   = active_id_q;
        arrived_d     = arrived_q;
        sync_enable_d = '0;
        tmo_d         = tmo_q;
        member        = '0;
        fresh         = '0;
        set_mis       = 1'b0;
        set_non       = 1'b0;
        set_dup       = 1'b0;
        set_tmo       = 1'b0;

        case (state_q)
            S_IDLE: begin
                member = sync_barrier_en_in & participant_mask;
                // With participant_mask == 0, every strobe is a non-member.
                set_non = ((sync_barrier_en_in & ~participant_mask) != '0);
                if (member != '0) begin
                    mask_d      = participant_mask;
                    active_id_d = first_id;
                    arrived_d   = member & id_match;
                    set_mis     = ((member & ~id_match) != '0);
                    tmo_d       = '0;
                    if ((member & id_match) == participant_mask) begin
                        state_d       = S_RELEASE;
                        sync_enable_d = participant_mask;
                    end else begin
                        state_d = S_COLLECT;
                    end
                end
            end

            S_COLLECT: begin
                member    = sync_barrier_en_in & mask_q;
                fresh     = member & ~arrived_q;
                set_non   = ((sync_barrier_en_in & ~mask_q) != '0);
                set_dup   = ((member & arrived_q) != '0);
                set_mis   = ((fresh & ~id_match) != '0);
                arrived_d = arrived_q | (fresh & id_match);
                if (tmo_q != '1) begin
                    tmo_d = tmo_q + TIMEOUT_WIDTH'(1);
                end
                // If the barrier completes in the same cycle that the timeout
                // expires, the release has priority.
                if ((arrived_q | (fresh & id_match)) == mask_q) begin
                    state_d       = S_RELEASE;
                    sync_enable_d = mask_q;
                end else if ((timeout_cycles != '0) &&
                             (tmo_q == timeout_cycles - TIMEOUT_WIDTH'(1))) begin
                    state_d = S_ERROR;
                    set_tmo = 1'b1;
                end
            end

            S_RELEASE: begin
                state_d   = S_IDLE;
                arrived_d = '0;
                set_non   = (sync_barrier_en_in != '0);
            end

            S_ERROR: begin
                // Strobes are ignored here and do not set any flag.
                if (clear_err) begin
                    state_d   = S_IDLE;
                    arrived_d = '0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A new error event in the same cycle as clear_err wins over the clear.
        err_mismatch_d  = (err_mismatch_q  & ~clear_err) | set_mis;
        err_nonmember_d = (err_nonmember_q & ~clear_err) | set_non;
        err_dup_d       = (err_dup_q       & ~clear_err) | set_dup;
        err_timeout_d   = (err_timeout_q   & ~clear_err) | set_tmo;
        busy_d          = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments, so that every flop
    // samples the values from before the edge, whatever the statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            mask_q          <= '0;
            active_id_q     <= '0;
            arrived_q       <= '0;
            sync_enable_q   <= '0;
            busy_q          <= 1'b0;
            tmo_q           <= '0;
            err_mismatch_q  <= 1'b0;
            err_nonmember_q <= 1'b0;
            err_dup_q       <= 1'b0;
            err_timeout_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            mask_q          <= mask_d;
            active_id_q     <= active_id_d;
            arrived_q       <= arrived_d;
            sync_enable_q   <= sync_enable_d;
            busy_q          <= busy_d;
            tmo_q           <= tmo_d;
            err_mismatch_q  <= err_mismatch_d;
            err_nonmember_q <= err_nonmember_d;
            err_dup_q       <= err_dup_d;
            err_timeout_q   <= err_timeout_d;
        end
    end

    assign sync_enable   = sync_enable_q;
    assign busy          = busy_q;
    assign active_id     = active_id_q;
    assign arrived       = arrived_q;
    assign err_mismatch  = err_mismatch_q;
    assign err_nonmember = err_nonmember_q;
    assign err_dup       = err_dup_q;
    assign err_timeout   = err_timeout_q;

endmodule

// File: tb/tb_sync_barrier_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sync_barrier_ctrl
//
// Directed bench for sync_barrier_ctrl with N_CORES=4. The stimulus thread
// pushes each expected release pulse (mask and cycle) into a queue. A monitor
// pops an entry whenever sync_enable is nonzero and compares the mask and the
// cycle. The stimulus thread also checks the registered status outputs
// against hand-computed values.
// -----------------------------------------------------------------------------
module tb_sync_barrier_ctrl;

    localparam int NC = 4;
    localparam int W  = 8;
    localparam int TW = 16;

    logic              clk;
    logic              reset;
    logic [NC*W-1:0]   sync_barrier;
    logic [NC-1:0]     sync_barrier_en_in;
    logic [NC-1:0]     participant_mask;
    logic [TW-1:0]     timeout_cycles;
    logic              clear_err;
    logic [NC-1:0]     sync_enable;
    logic              busy;
    logic [W-1:0]      active_id;
    logic [NC-1:0]     arrived;
    logic              err_mismatch;
    logic              err_nonmember;
    logic              err_dup;
    logic              err_timeout;

    typedef struct {
        logic [NC-1:0] mask;
        int            cyc;
    } rel_t;

    rel_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    sync_barrier_ctrl #(
        .N_CORES            (NC),
        .SYNC_BARRIER_WIDTH (W),
        .TIMEOUT_WIDTH      (TW)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .sync_barrier       (sync_barrier),
        .sync_barrier_en_in (sync_barrier_en_in),
        .participant_mask   (participant_mask),
        .timeout_cycles     (timeout_cycles),
        .clear_err          (clear_err),
        .sync_enable        (sync_enable),
        .busy               (busy),
        .active_id          (active_id),
        .arrived            (arrived),
        .err_mismatch       (err_mismatch),
        .err_nonmember      (err_nonmember),
        .err_dup            (err_dup),
        .err_timeout        (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: each nonzero sync_enable must match the oldest expected release.
    always @(negedge clk) begin
        if (sync_enable != '0) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_release: got=%b expected=none (cycle %0d)", sync_enable, cyc);
            end else begin
                rel_t e;
                e = exp_q.pop_front();
                check("release_mask", 32'(sync_enable), 32'(e.mask));
                check("release_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Drive one strobe vector so that it is sampled on the next rising edge,
    // then return 1 time unit after that edge.
    task automatic strobe(input logic [NC-1:0] en, input logic [NC*W-1:0] ids);
        sync_barrier       = ids;
        sync_barrier_en_in = en;
        @(posedge clk);
        #1;
        sync_barrier_en_in = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        @(posedge clk);
        #1;
        clear_err = 1'b0;
    endtask

    task automatic expect_release(input logic [NC-1:0] m);
        rel_t e;
        e.mask = m;
        e.cyc  = cyc;
        exp_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset              = 1'b1;
        sync_barrier       = '0;
        sync_barrier_en_in = '0;
        participant_mask   = '0;
        timeout_cycles     = '0;
        clear_err          = 1'b0;
        #3;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_sync_enable", 32'(sync_enable), 32'd0);
        check("reset_active_id", 32'(active_id), 32'd0);
        check("reset_flags", 32'({err_mismatch, err_nonmember, err_dup, err_timeout}), 32'd0);
        idle(2);
        reset = 1'b0;

        // Scenario 1: four staggered arrivals with ID 05. The mask is latched on
        // the first arrival, so a later change of participant_mask is ignored.
        participant_mask = 4'b1111;
        strobe(4'b0001, 32'h05050505);
        check("s1_busy_collect", 32'(busy), 32'd1);
        check("s1_active_id", 32'(active_id), 32'h05);
        check("s1_arrived_1", 32'(arrived), 32'b0001);
        participant_mask = 4'b0001;
        idle(1);
        strobe(4'b0010, 32'h05050505);
        strobe(4'b0100, 32'h05050505);
        check("s1_arrived_3", 32'(arrived), 32'b0111);
        idle(6);
        check("s1_still_busy", 32'(busy), 32'd1);
        strobe(4'b1000, 32'h05050505);
        expect_release(4'b1111);
        check("s1_busy_release", 32'(busy), 32'd1);
        idle(1);
        check("s1_busy_done", 32'(busy), 32'd0);
        check("s1_arrived_cleared", 32'(arrived), 32'd0);

        // Scenario 2: both members arrive in the same cycle, so COLLECT is skipped.
        participant_mask = 4'b0101;
        strobe(4'b0101, 32'h00030003);
        expect_release(4'b0101);
        check("s2_active_id", 32'(active_id), 32'h03);
        check("s2_arrived", 32'(arrived), 32'b0101);
        idle(1);
        check("s2_idle", 32'(busy), 32'd0);

        // Scenario 3: ID mismatch, then the correct ID completes the barrier.
        participant_mask = 4'b0011;
        strobe(4'b0001, 32'h00000001);
        strobe(4'b0010, 32'h00000200);
        check("s3_err_mismatch", 32'(err_mismatch), 32'd1);
        check("s3_arrived", 32'(arrived), 32'b0001);
        strobe(4'b0010, 32'h00000100);
        expect_release(4'b0011);
        idle(1);
        pulse_clear();
        check("s3_mismatch_cleared", 32'(err_mismatch), 32'd0);

        // Scenario 4: timeout after exactly 8 COLLECT cycles. Strobes in ERROR
        // are ignored.
        timeout_cycles = 16'd8;
        strobe(4'b0001, 32'h00000007);
        idle(7);
        check("s4_no_timeout_yet", 32'(err_timeout), 32'd0);
        idle(1);
        check("s4_err_timeout", 32'(err_timeout), 32'd1);
        check("s4_busy_error", 32'(busy), 32'd1);
        strobe(4'b1010, 32'h00000707);
        check("s4_error_ignores", 32'({arrived, err_nonmember, err_mismatch, err_dup}), 32'({4'b0001, 3'b000}));
        pulse_clear();
        check("s4_cleared_idle", 32'(busy), 32'd0);
        check("s4_cleared_flags", 32'({err_mismatch, err_nonmember, err_dup, err_timeout, arrived}), 32'd0);
        timeout_cycles = '0;

        // Scenario 5: non-member and duplicate strobes. A new error in the same
        // cycle as clear_err wins over the clear.
        participant_mask = 4'b0000;
        strobe(4'b0001, 32'h00000009);
        check("s5_mask0_nonmember", 32'(err_nonmember), 32'd1);
        check("s5_mask0_idle", 32'(busy), 32'd0);
        pulse_clear();
        check("s5_clear_outside_error", 32'(err_nonmember), 32'd0);
        participant_mask = 4'b0011;
        strobe(4'b1000, 32'h09000000);
        check("s5_core3_nonmember", 32'(err_nonmember), 32'd1);
        check("s5_core3_idle", 32'(busy), 32'd0);
        strobe(4'b0001, 32'h00000009);
        strobe(4'b0001, 32'h00000009);
        check("s5_err_dup", 32'(err_dup), 32'd1);
        check("s5_dup_arrived", 32'(arrived), 32'b0001);
        clear_err = 1'b1;
        strobe(4'b1000, 32'h09000009);
        clear_err = 1'b0;
        check("s5_set_wins", 32'({err_nonmember, err_dup}), 32'b10);
        strobe(4'b0010, 32'h00000900);
        expect_release(4'b0011);
        idle(2);

        // Scenario 6: asynchronous reset during COLLECT abandons the barrier. A
        // strobe on the first edge after deassertion is honored.
        strobe(4'b0001, 32'h00000004);
        check("s6_arrived_before", 32'(arrived), 32'b0001);
        #2;
        reset = 1'b1;
        #1;
        check("s6_async_busy", 32'(busy), 32'd0);
        check("s6_async_arrived", 32'(arrived), 32'd0);
        check("s6_async_id", 32'(active_id), 32'd0);
        check("s6_async_flags", 32'({err_mismatch, err_nonmember, err_dup, err_timeout, sync_enable}), 32'd0);
        idle(2);
        reset = 1'b0;
        strobe(4'b0011, 32'h00000404);
        expect_release(4'b0011);
        idle(3);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
